// File: rtl/stream_fifo_pkg.sv
// Shared types and width helpers for the stream_fifo_q2 queue family.
package stream_fifo_pkg;

    localparam int DEF_DATA_BITS = 32;
    localparam int DEF_STRB_BITS = 4;

    typedef struct packed {
        logic [DEF_STRB_BITS-1:0] strb;
        logic [DEF_DATA_BITS-1:0] data;
        logic                     last;
    } beat_t;

    // Count must represent 0..depth inclusive, hence depth+1 states.
    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Wrap at depth-1 rather than at a power of two.
    function automatic logic [31:0] ptr_wrap(input logic [31:0] ptr, input logic [31:0] depth);
        return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/stream_fifo_ptr.sv
// Wrap-around slot pointer for stream_fifo_q2; sync clear, async reset to 0.
module stream_fifo_ptr
    import stream_fifo_pkg::*;
#(
    parameter int p_DEPTH    = 4,
    parameter int p_PTR_BITS = ptr_bits(p_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    output logic [p_PTR_BITS-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= p_PTR_BITS'(ptr_wrap(32'(ptr), 32'(p_DEPTH)));
        end
    end

endmodule

// File: rtl/stream_fifo_q2.sv
// Ready/valid stream FIFO with occupancy count, almost-full and flush.
// Define STREAM_FIFO_PKT_MODE_EN for store-and-forward packet mode.
module stream_fifo_q2
    import stream_fifo_pkg::*;
#(
    parameter int p_DATA_BITS    = 32,
    parameter int p_STRB_BITS    = 4,
    parameter int p_FIFO_DEPTH   = 4,
    parameter int p_AFULL_THRESH = 3,
    parameter int p_PIPE         = 0,
    parameter int p_FLOW         = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 enq_valid,
    output logic                                 enq_ready,
    input  logic [p_STRB_BITS-1:0]               enq_bits_strb,
    input  logic [p_DATA_BITS-1:0]               enq_bits_data,
    input  logic                                 enq_bits_last,
    output logic                                 deq_valid,
    input  logic                                 deq_ready,
    output logic [p_STRB_BITS-1:0]               deq_bits_strb,
    output logic [p_DATA_BITS-1:0]               deq_bits_data,
    output logic                                 deq_bits_last,
    output logic [$clog2(p_FIFO_DEPTH+1)-1:0]    count,
    output logic                                 almost_full
);

    localparam int CNT_BITS = cnt_bits(p_FIFO_DEPTH);
    localparam int PTR_BITS = ptr_bits(p_FIFO_DEPTH);
    localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(p_FIFO_DEPTH);
    localparam logic [CNT_BITS-1:0] AFULL_C = CNT_BITS'(p_AFULL_THRESH);
    localparam bit PIPE_EN = (p_PIPE != 0);
`ifdef STREAM_FIFO_PKT_MODE_EN
    localparam bit PKT_MODE = 1'b1;
`else
    localparam bit PKT_MODE = 1'b0;
`endif
    // Packet mode must see every beat in storage, so the bypass is disabled there.
    localparam bit FLOW_EN = (p_FLOW != 0) && !PKT_MODE;

    typedef struct packed {
        logic [p_STRB_BITS-1:0] strb;
        logic [p_DATA_BITS-1:0] data;
        logic                   last;
    } q_beat_t;

    q_beat_t               mem [p_FIFO_DEPTH];
    q_beat_t               enq_beat;
    q_beat_t               head_beat;
    logic [PTR_BITS-1:0]   enq_ptr;
    logic [PTR_BITS-1:0]   deq_ptr;
    logic [CNT_BITS-1:0]   count_q;
    logic [CNT_BITS-1:0]   count_nxt;
    logic                  full;
    logic                  empty;
    logic                  release_ok;
    logic                  bypass;
    logic                  pass;
    logic                  enq_fire;
    logic                  deq_fire;
    logic                  do_wr;
    logic                  do_rd;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

`ifdef STREAM_FIFO_PKT_MODE_EN
    logic [CNT_BITS-1:0] pkt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else if (flush) begin
            pkt_cnt <= '0;
        end else if ((enq_fire && enq_bits_last) && !(deq_fire && deq_bits_last)) begin
            pkt_cnt <= pkt_cnt + 1'b1;
        end else if (!(enq_fire && enq_bits_last) && (deq_fire && deq_bits_last)) begin
            pkt_cnt <= pkt_cnt - 1'b1;
        end
    end

    // Full with no complete packet would deadlock; let the oversize packet drain.
    assign release_ok = (pkt_cnt != '0) || full;
`else
    assign release_ok = 1'b1;
`endif

    assign enq_beat  = {enq_bits_strb, enq_bits_data, enq_bits_last};
    assign bypass    = FLOW_EN && empty && enq_valid && !flush;
    assign head_beat = bypass ? enq_beat : mem[deq_ptr];

    assign enq_ready = (!full || (PIPE_EN && deq_ready)) && !flush;
    assign deq_valid = !flush && ((!empty && release_ok) || bypass);

    assign deq_bits_strb = head_beat.strb;
    assign deq_bits_data = head_beat.data;
    assign deq_bits_last = head_beat.last;

    assign enq_fire = enq_valid && enq_ready;
    assign deq_fire = deq_valid && deq_ready;
    assign pass     = bypass && deq_ready;
    assign do_wr    = enq_fire && !pass;
    assign do_rd    = deq_fire && !pass;

    assign count_nxt = flush ? '0 : (count_q + CNT_BITS'(do_wr) - CNT_BITS'(do_rd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            almost_full <= 1'b0;
        end else begin
            count_q     <= count_nxt;
            almost_full <= (count_nxt >= AFULL_C);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < p_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_wr) begin
            mem[enq_ptr] <= enq_beat;
        end
    end

    assign count = count_q;

    stream_fifo_ptr #(
        .p_DEPTH    (p_FIFO_DEPTH),
        .p_PTR_BITS (PTR_BITS)
    ) u_enq_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (do_wr),
        .ptr   (enq_ptr)
    );

    stream_fifo_ptr #(
        .p_DEPTH    (p_FIFO_DEPTH),
        .p_PTR_BITS (PTR_BITS)
    ) u_deq_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (do_rd),
        .ptr   (deq_ptr)
    );

endmodule

// File: tb/tb_stream_fifo_q2.sv
// Bench for stream_fifo_q2: four configurations share one stimulus stream, each checked by a queue model.
module tb_stream_fifo_q2;

`ifdef STREAM_FIFO_PKT_MODE_EN
    localparam bit PKT = 1'b1;
`else
    localparam bit PKT = 1'b0;
`endif
    localparam int NI = 4;
    localparam int DEP [NI] = '{4, 3, 4, 4};
    localparam int THR [NI] = '{3, 2, 3, 3};
    localparam int PIP [NI] = '{0, 0, 1, 0};
    localparam int FLW [NI] = '{0, 0, 0, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        enq_valid;
    logic [3:0]  enq_strb;
    logic [31:0] enq_data;
    logic        enq_last;
    logic        deq_ready;

    logic        er    [NI];
    logic        dv    [NI];
    logic        dlast [NI];
    logic        af    [NI];
    logic [3:0]  dstrb [NI];
    logic [31:0] ddata [NI];
    logic [2:0]  cnt0, cnt2, cnt3;
    logic [1:0]  cnt1;
    logic [2:0]  cnt   [NI];

    assign cnt[0] = cnt0;
    assign cnt[1] = {1'b0, cnt1};
    assign cnt[2] = cnt2;
    assign cnt[3] = cnt3;

    always #5 clk = ~clk;

    stream_fifo_q2 u_d4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(er[0]),
        .enq_bits_strb(enq_strb), .enq_bits_data(enq_data), .enq_bits_last(enq_last),
        .deq_valid(dv[0]), .deq_ready(deq_ready),
        .deq_bits_strb(dstrb[0]), .deq_bits_data(ddata[0]), .deq_bits_last(dlast[0]),
        .count(cnt0), .almost_full(af[0])
    );

    stream_fifo_q2 #(.p_FIFO_DEPTH(3), .p_AFULL_THRESH(2)) u_d3 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(er[1]),
        .enq_bits_strb(enq_strb), .enq_bits_data(enq_data), .enq_bits_last(enq_last),
        .deq_valid(dv[1]), .deq_ready(deq_ready),
        .deq_bits_strb(dstrb[1]), .deq_bits_data(ddata[1]), .deq_bits_last(dlast[1]),
        .count(cnt1), .almost_full(af[1])
    );

    stream_fifo_q2 #(.p_PIPE(1)) u_pipe (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(er[2]),
        .enq_bits_strb(enq_strb), .enq_bits_data(enq_data), .enq_bits_last(enq_last),
        .deq_valid(dv[2]), .deq_ready(deq_ready),
        .deq_bits_strb(dstrb[2]), .deq_bits_data(ddata[2]), .deq_bits_last(dlast[2]),
        .count(cnt2), .almost_full(af[2])
    );

    stream_fifo_q2 #(.p_FLOW(1)) u_flow (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(er[3]),
        .enq_bits_strb(enq_strb), .enq_bits_data(enq_data), .enq_bits_last(enq_last),
        .deq_valid(dv[3]), .deq_ready(deq_ready),
        .deq_bits_strb(dstrb[3]), .deq_bits_data(ddata[3]), .deq_bits_last(dlast[3]),
        .count(cnt3), .almost_full(af[3])
    );

    typedef logic [36:0] bq_t [$];
    bq_t         mq [NI];
    logic        pop_p  [NI];
    logic        push_p [NI];
    logic        clr_p;
    logic [36:0] pend_beat;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        bit          ev;
        logic [31:0] d;
        bit          dr;
        bit          x_er;
        bit          x_dv;
        logic [31:0] x_d;
        int          x_cnt;
        bit          x_af;
    } vec_t;
    vec_t tv [10];

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic drive(input bit ev, input logic [31:0] d, input bit l, input bit dr, input bit fl);
        enq_valid = ev;
        enq_data  = d;
        enq_strb  = d[7:4];
        enq_last  = l;
        deq_ready = dr;
        flush     = fl;
    endtask

    // Reference: FIFO as a queue; packet readiness = any stored beat with last set.
    task automatic settle();
        logic [36:0] inb;
        logic [36:0] b;
        int  n, nl;
        bit  full, e_er, byp, e_dv;
        #1;
        inb = {enq_strb, enq_data, enq_last};
        pend_beat = inb;
        clr_p = flush;
        for (int k = 0; k < NI; k++) begin
            n  = mq[k].size();
            nl = 0;
            for (int j = 0; j < n; j++) begin
                b = mq[k][j];
                if (b[0]) nl++;
            end
            full = (n == DEP[k]);
            e_er = !flush && (!full || (PIP[k] != 0 && deq_ready));
            byp  = !PKT && (FLW[k] != 0) && (n == 0) && enq_valid && !flush;
            e_dv = !flush && (byp || (n > 0 && (!PKT || nl > 0 || full)));
            chk("enq_ready", k, 64'(er[k]), 64'(e_er));
            chk("deq_valid", k, 64'(dv[k]), 64'(e_dv));
            if (e_dv) chk("deq_beat", k, 64'({dstrb[k], ddata[k], dlast[k]}), 64'(byp ? inb : mq[k][0]));
            chk("count", k, 64'(cnt[k]), 64'(n));
            chk("almost_full", k, 64'(af[k]), 64'(n >= THR[k]));
            push_p[k] = enq_valid && e_er && !(byp && deq_ready);
            pop_p[k]  = e_dv && deq_ready && !(byp && deq_ready);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (!rst_n || clr_p) begin
                mq[k].delete();
            end else begin
                if (pop_p[k]) void'(mq[k].pop_front());
                if (push_p[k]) mq[k].push_back(pend_beat);
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic do_reset();
        drive(0, 32'h0, 0, 0, 0);
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) mq[k].delete();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 32'h0, 0, 0, 0);
        @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("rst_enq_ready", k, 64'(er[k]), 64'd1);
            chk("rst_deq_valid", k, 64'(dv[k]), 64'd0);
            chk("rst_deq_bits", k, 64'({dstrb[k], ddata[k], dlast[k]}), 64'd0);
            chk("rst_count", k, 64'(cnt[k]), 64'd0);
            chk("rst_almost_full", k, 64'(af[k]), 64'd0);
        end
        @(negedge clk);
        do_reset();

        // Fill to full with no consumer, then drain in order.
        tv[0] = '{1, 32'hA0, 0, 1, 0, 32'h00, 0, 0};
        tv[1] = '{1, 32'hA1, 0, 1, 1, 32'hA0, 1, 0};
        tv[2] = '{1, 32'hA2, 0, 1, 1, 32'hA0, 2, 0};
        tv[3] = '{1, 32'hA3, 0, 1, 1, 32'hA0, 3, 1};
        tv[4] = '{1, 32'hA4, 0, 0, 1, 32'hA0, 4, 1};
        tv[5] = '{0, 32'h00, 1, 0, 1, 32'hA0, 4, 1};
        tv[6] = '{0, 32'h00, 1, 1, 1, 32'hA1, 3, 1};
        tv[7] = '{0, 32'h00, 1, 1, 1, 32'hA2, 2, 0};
        tv[8] = '{0, 32'h00, 1, 1, 1, 32'hA3, 1, 0};
        tv[9] = '{0, 32'h00, 0, 1, 0, 32'h00, 0, 0};
        for (int i = 0; i < 10; i++) begin
            drive(tv[i].ev, tv[i].d, 1, tv[i].dr, 0);
            settle();
            chk("t1_enq_ready", i, 64'(er[0]), 64'(tv[i].x_er));
            chk("t1_deq_valid", i, 64'(dv[0]), 64'(tv[i].x_dv));
            if (tv[i].x_dv) chk("t1_deq_data", i, 64'(ddata[0]), 64'(tv[i].x_d));
            chk("t1_count", i, 64'(cnt[0]), 64'(tv[i].x_cnt));
            chk("t1_almost_full", i, 64'(af[0]), 64'(tv[i].x_af));
            advance();
        end

        // PIPE: replace into the freed slot while full.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'hB0 + 32'(i), 1, 0, 0);
            step();
        end
        drive(1, 32'hB4, 1, 1, 0);
        settle();
        chk("pipe_enq_ready", 2, 64'(er[2]), 64'd1);
        chk("pipe_head", 2, 64'(ddata[2]), 64'hB0);
        advance();
        for (int i = 1; i <= 4; i++) begin
            drive(0, 32'h0, 0, 1, 0);
            settle();
            if (i == 1) chk("pipe_count_full", 2, 64'(cnt[2]), 64'd4);
            chk("pipe_order", 2, 64'(ddata[2]), 64'hB0 + 64'(i));
            advance();
        end

`ifndef STREAM_FIFO_PKT_MODE_EN
        // FLOW: empty-queue bypass, nothing stored.
        do_reset();
        drive(1, 32'hC0, 1, 1, 0);
        settle();
        chk("flow_deq_valid", 3, 64'(dv[3]), 64'd1);
        chk("flow_deq_data", 3, 64'(ddata[3]), 64'hC0);
        advance();
        drive(0, 32'h0, 0, 0, 0);
        settle();
        chk("flow_count", 3, 64'(cnt[3]), 64'd0);
        advance();
`endif

        // Flush with a concurrent enqueue attempt.
        do_reset();
        drive(1, 32'hD0, 1, 0, 0); step();
        drive(1, 32'hD1, 1, 0, 0); step();
        drive(1, 32'hD9, 1, 0, 1);
        settle();
        chk("flush_enq_ready", 0, 64'(er[0]), 64'd0);
        chk("flush_deq_valid", 0, 64'(dv[0]), 64'd0);
        advance();
        drive(0, 32'h0, 0, 1, 0);
        settle();
        chk("post_flush_count", 0, 64'(cnt[0]), 64'd0);
        chk("post_flush_deq_valid", 0, 64'(dv[0]), 64'd0);
        advance();

        // Asynchronous reset between clock edges mid-stream.
        drive(1, 32'hD2, 1, 0, 0); step();
        drive(1, 32'hD3, 1, 0, 0); step();
        drive(0, 32'h0, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) mq[k].delete();
        settle();
        chk("async_rst_count", 0, 64'(cnt[0]), 64'd0);
        chk("async_rst_deq_valid", 0, 64'(dv[0]), 64'd0);
        advance();
        rst_n = 1'b1;

`ifdef STREAM_FIFO_PKT_MODE_EN
        // Store-and-forward: hold until a last beat, release on full.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'hE0 + 32'(i), 0, 0, 0);
            step();
        end
        drive(1, 32'hE3, 1, 0, 0);
        settle();
        chk("pkt_hold", 0, 64'(dv[0]), 64'd0);
        advance();
        drive(0, 32'h0, 0, 0, 0);
        settle();
        chk("pkt_release", 0, 64'(dv[0]), 64'd1);
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h0, 0, 1, 0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'hF0 + 32'(i), 0, 0, 0);
            step();
        end
        drive(1, 32'hF4, 0, 0, 0);
        settle();
        chk("pkt_full_release", 0, 64'(dv[0]), 64'd1);
        chk("pkt_full_head", 0, 64'(ddata[0]), 64'hF0);
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(0, 32'h0, 0, 1, 0);
            step();
        end
`endif

        // Randomized traffic with alternating consumer pressure and rare flushes.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
                  ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 59) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
